// File: rtl/stepper_phase_decoder.sv
// Receive-side monitor for the 4-phase half-step stepper drive bus: filters the coil lines,
// tracks the half-step phase, counts signed position and reports step timing, motion and faults.
module stepper_phase_decoder #(
  parameter int POS_W         = 16,
  parameter int PER_W         = 24,
  parameter int STABLE_CYCLES = 16,
  parameter int IDLE_CYCLES   = 1_000_000
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic             PH_A,
  input  logic             PH_B,
  input  logic             PH_C,
  input  logic             PH_D,
  input  logic             CLR_POS,
  input  logic             CLR_ERR,
  output logic [POS_W-1:0] POSITION,
  output logic             STEP_FWD,
  output logic             STEP_REV,
  output logic             DIR,
  output logic             MOVING,
  output logic [2:0]       PHASE_IDX,
  output logic             PHASE_VALID,
  output logic [PER_W-1:0] STEP_PERIOD,
  output logic             PERIOD_VALID,
  output logic             ERR_ILLEGAL,
  output logic             ERR_SKIP
);

  localparam int                STAB_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_FULL = STAB_W'(STABLE_CYCLES);
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);
  localparam logic [PER_W-1:0]  PER_IDLE  = PER_W'(IDLE_CYCLES);
  localparam logic [PER_W-1:0]  PER_MAX   = {PER_W{1'b1}};
  localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Returns {legal, index}; released (0000) and illegal patterns both report legal = 0.
  function automatic logic [3:0] decode_phase(input logic [3:0] pat);
    logic [3:0] res;
    case (pat)
      4'b1000: res = {1'b1, 3'd0};
      4'b1100: res = {1'b1, 3'd1};
      4'b0100: res = {1'b1, 3'd2};
      4'b0110: res = {1'b1, 3'd3};
      4'b0010: res = {1'b1, 3'd4};
      4'b0011: res = {1'b1, 3'd5};
      4'b0001: res = {1'b1, 3'd6};
      4'b1001: res = {1'b1, 3'd7};
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  logic [3:0]        r_sync1;
  logic [3:0]        r_sync2;
  logic [3:0]        r_cand;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [3:0]        r_filt;
  logic              r_f_upd;

  state_t            r_state;
  logic [POS_W-1:0]  r_position;
  logic              r_step_fwd;
  logic              r_step_rev;
  logic              r_dir;
  logic              r_moving;
  logic [2:0]        r_phase_idx;
  logic              r_phase_valid;
  logic [PER_W-1:0]  r_step_period;
  logic              r_period_valid;
  logic              r_err_ill;
  logic              r_err_skip;
  logic [PER_W-1:0]  r_per_cnt;
  logic              r_had_step;

  state_t            w_state_nx;
  logic [POS_W-1:0]  w_position_nx;
  logic              w_step_fwd_nx;
  logic              w_step_rev_nx;
  logic              w_dir_nx;
  logic              w_moving_nx;
  logic [2:0]        w_phase_idx_nx;
  logic              w_phase_valid_nx;
  logic [PER_W-1:0]  w_step_period_nx;
  logic              w_period_valid_nx;
  logic              w_err_ill_nx;
  logic              w_err_skip_nx;
  logic [PER_W-1:0]  w_per_cnt_nx;
  logic              w_had_step_nx;
  logic              w_step;
  logic              w_set_ill;
  logic              w_set_skip;
  logic              w_go_idle;

  logic [3:0]        w_dec;
  logic              w_legal;
  logic [2:0]        w_new_idx;
  logic              w_released;
  logic [2:0]        w_delta;

  assign w_dec      = decode_phase(r_filt);
  assign w_legal    = w_dec[3];
  assign w_new_idx  = w_dec[2:0];
  assign w_released = (r_filt == 4'b0000);
  assign w_delta    = w_new_idx - r_phase_idx;

  // Two-flop synchroniser on the asynchronous coil lines, packed as {A,B,C,D}.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= {PH_A, PH_B, PH_C, PH_D};
      r_sync2 <= r_sync1;
    end
  end

  // Stability filter: a pattern is accepted on its STABLE_CYCLES-th consecutive sample;
  // r_f_upd strobes only when the accepted pattern differs from the current one.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_cand     <= 4'b0000;
      r_stab_cnt <= '0;
      r_filt     <= 4'b0000;
      r_f_upd    <= 1'b0;
    end else if (r_sync2 != r_cand) begin
      r_cand     <= r_sync2;
      r_stab_cnt <= STAB_ONE;
      r_f_upd    <= 1'b0;
    end else if (r_stab_cnt == STAB_LAST) begin
      r_stab_cnt <= STAB_FULL;
      r_filt     <= r_cand;
      r_f_upd    <= (r_cand != r_filt);
    end else if (r_stab_cnt < STAB_LAST) begin
      r_stab_cnt <= r_stab_cnt + STAB_ONE;
      r_f_upd    <= 1'b0;
    end else begin
      r_f_upd    <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and next-output logic, evaluated against the filtered pattern.
  always_comb begin
    w_state_nx        = r_state;
    w_position_nx     = r_position;
    w_step_fwd_nx     = 1'b0;
    w_step_rev_nx     = 1'b0;
    w_dir_nx          = r_dir;
    w_moving_nx       = r_moving;
    w_phase_idx_nx    = r_phase_idx;
    w_phase_valid_nx  = r_phase_valid;
    w_step_period_nx  = r_step_period;
    w_period_valid_nx = r_period_valid;
    w_err_ill_nx      = r_err_ill;
    w_err_skip_nx     = r_err_skip;
    w_per_cnt_nx      = r_per_cnt;
    w_had_step_nx     = r_had_step;
    w_step            = 1'b0;
    w_set_ill         = 1'b0;
    w_set_skip        = 1'b0;
    w_go_idle         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_f_upd && !w_released) begin
          if (w_legal) begin
            w_state_nx       = ST_TRACK;
            w_phase_idx_nx   = w_new_idx;
            w_phase_valid_nx = 1'b1;
            w_had_step_nx    = 1'b0;
          end else begin
            w_set_ill = 1'b1;
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (!r_f_upd) begin
          w_state_nx = ST_TRACK;
        end else if (w_released) begin
          w_go_idle = 1'b1;
        end else if (!w_legal) begin
          w_set_ill = 1'b1;
          w_go_idle = 1'b1;
        end else if (w_delta == 3'd1) begin
          w_step_fwd_nx  = 1'b1;
          w_position_nx  = r_position + POS_ONE;
          w_dir_nx       = 1'b1;
          w_phase_idx_nx = w_new_idx;
        end else if (w_delta == 3'd7) begin
          w_step_rev_nx  = 1'b1;
          w_position_nx  = r_position - POS_ONE;
          w_dir_nx       = 1'b0;
          w_phase_idx_nx = w_new_idx;
        end else if (w_delta != 3'd0) begin
          w_set_skip     = 1'b1;
          w_phase_idx_nx = w_new_idx;
        end else begin
          w_state_nx = ST_TRACK;
        end
      end
      default: begin
        w_go_idle = 1'b1;
      end
    endcase

    w_step = w_step_fwd_nx | w_step_rev_nx;

    if (w_go_idle) begin
      w_state_nx        = ST_IDLE;
      w_phase_valid_nx  = 1'b0;
      w_period_valid_nx = 1'b0;
      w_had_step_nx     = 1'b0;
    end else begin
      w_state_nx = w_state_nx;
    end

    // A period is only trusted once two steps have been seen in the same tracking run.
    if (w_step) begin
      w_step_period_nx  = r_per_cnt;
      w_per_cnt_nx      = PER_ONE;
      w_period_valid_nx = r_had_step;
      w_had_step_nx     = 1'b1;
    end else if (r_per_cnt != PER_MAX) begin
      w_per_cnt_nx = r_per_cnt + PER_ONE;
    end else begin
      w_per_cnt_nx = r_per_cnt;
    end

    if (w_state_nx == ST_IDLE) begin
      w_moving_nx = 1'b0;
    end else if (w_step) begin
      w_moving_nx = 1'b1;
    end else if (r_per_cnt == PER_IDLE) begin
      w_moving_nx = 1'b0;
    end else begin
      w_moving_nx = r_moving;
    end

    if (w_set_ill) begin
      w_err_ill_nx = 1'b1;
    end else if (CLR_ERR) begin
      w_err_ill_nx = 1'b0;
    end else begin
      w_err_ill_nx = r_err_ill;
    end

    if (w_set_skip) begin
      w_err_skip_nx = 1'b1;
    end else if (CLR_ERR) begin
      w_err_skip_nx = 1'b0;
    end else begin
      w_err_skip_nx = r_err_skip;
    end

    if (CLR_POS) begin
      w_position_nx = '0;
    end else begin
      w_position_nx = w_position_nx;
    end
  end

  // Registered outputs and tracking datapath.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_position     <= '0;
      r_step_fwd     <= 1'b0;
      r_step_rev     <= 1'b0;
      r_dir          <= 1'b0;
      r_moving       <= 1'b0;
      r_phase_idx    <= 3'd0;
      r_phase_valid  <= 1'b0;
      r_step_period  <= '0;
      r_period_valid <= 1'b0;
      r_err_ill      <= 1'b0;
      r_err_skip     <= 1'b0;
      r_per_cnt      <= '0;
      r_had_step     <= 1'b0;
    end else begin
      r_position     <= w_position_nx;
      r_step_fwd     <= w_step_fwd_nx;
      r_step_rev     <= w_step_rev_nx;
      r_dir          <= w_dir_nx;
      r_moving       <= w_moving_nx;
      r_phase_idx    <= w_phase_idx_nx;
      r_phase_valid  <= w_phase_valid_nx;
      r_step_period  <= w_step_period_nx;
      r_period_valid <= w_period_valid_nx;
      r_err_ill      <= w_err_ill_nx;
      r_err_skip     <= w_err_skip_nx;
      r_per_cnt      <= w_per_cnt_nx;
      r_had_step     <= w_had_step_nx;
    end
  end

  assign POSITION     = r_position;
  assign STEP_FWD     = r_step_fwd;
  assign STEP_REV     = r_step_rev;
  assign DIR          = r_dir;
  assign MOVING       = r_moving;
  assign PHASE_IDX    = r_phase_idx;
  assign PHASE_VALID  = r_phase_valid;
  assign STEP_PERIOD  = r_step_period;
  assign PERIOD_VALID = r_period_valid;
  assign ERR_ILLEGAL  = r_err_ill;
  assign ERR_SKIP     = r_err_skip;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed bench for stepper_phase_decoder: a vector table for the main stepping sequences
// plus hand-written sequences for filter, latency, idle timeout, reset and clear collisions.
module tb_stepper_phase_decoder;

  localparam int IDLE_T = 3000;
  localparam int STABLE = 16;
  localparam int LAT    = STABLE + 3;

  logic        CLK_50M = 1'b0;
  logic        RST_N;
  logic [3:0]  pins;
  logic        CLR_POS;
  logic        CLR_ERR;
  logic [15:0] POSITION;
  logic        STEP_FWD, STEP_REV, DIR, MOVING, PHASE_VALID, PERIOD_VALID, ERR_ILLEGAL, ERR_SKIP;
  logic [2:0]  PHASE_IDX;
  logic [23:0] STEP_PERIOD;

  stepper_phase_decoder #(
    .POS_W(16), .PER_W(24), .STABLE_CYCLES(STABLE), .IDLE_CYCLES(IDLE_T)
  ) dut (
    .CLK_50M(CLK_50M), .RST_N(RST_N),
    .PH_A(pins[3]), .PH_B(pins[2]), .PH_C(pins[1]), .PH_D(pins[0]),
    .CLR_POS(CLR_POS), .CLR_ERR(CLR_ERR),
    .POSITION(POSITION), .STEP_FWD(STEP_FWD), .STEP_REV(STEP_REV), .DIR(DIR),
    .MOVING(MOVING), .PHASE_IDX(PHASE_IDX), .PHASE_VALID(PHASE_VALID),
    .STEP_PERIOD(STEP_PERIOD), .PERIOD_VALID(PERIOD_VALID),
    .ERR_ILLEGAL(ERR_ILLEGAL), .ERR_SKIP(ERR_SKIP)
  );

  always #10 CLK_50M = ~CLK_50M;

  int fwd_total = 0;
  int rev_total = 0;
  always @(negedge CLK_50M) begin
    if (STEP_FWD) fwd_total <= fwd_total + 1;
    if (STEP_REV) rev_total <= rev_total + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  pat;
    int          hold;
    logic        clr_pos;
    logic        clr_err;
    logic [15:0] pos;
    int          fwd;
    int          rev;
    logic        dir;
    logic [2:0]  idx;
    logic        pv;
    logic        ill;
    logic        skip;
    logic        mov;
    logic        perv;
    logic        chk_per;
    int          per;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] pat, input int hold, input logic cp, input logic ce,
                              input logic [15:0] pos, input int fwd, input int rev, input logic dir,
                              input logic [2:0] idx, input logic pv, input logic ill, input logic skip,
                              input logic mov, input logic perv, input logic chk, input int per);
    vec_t v;
    v.pat = pat; v.hold = hold; v.clr_pos = cp; v.clr_err = ce; v.pos = pos;
    v.fwd = fwd; v.rev = rev; v.dir = dir; v.idx = idx; v.pv = pv; v.ill = ill;
    v.skip = skip; v.mov = mov; v.perv = perv; v.chk_per = chk; v.per = per;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int n);
    int f0, r0;
    f0 = fwd_total;
    r0 = rev_total;
    pins = v.pat; CLR_POS = v.clr_pos; CLR_ERR = v.clr_err;
    @(posedge CLK_50M);
    #1;
    CLR_POS = 1'b0; CLR_ERR = 1'b0;
    repeat (v.hold - 1) @(posedge CLK_50M);
    @(negedge CLK_50M);
    #1;
    check($sformatf("v%0d position", n), POSITION, v.pos);
    check($sformatf("v%0d fwd pulses", n), fwd_total - f0, v.fwd);
    check($sformatf("v%0d rev pulses", n), rev_total - r0, v.rev);
    check($sformatf("v%0d dir", n), DIR, v.dir);
    check($sformatf("v%0d phase_idx", n), PHASE_IDX, v.idx);
    check($sformatf("v%0d phase_valid", n), PHASE_VALID, v.pv);
    check($sformatf("v%0d err_illegal", n), ERR_ILLEGAL, v.ill);
    check($sformatf("v%0d err_skip", n), ERR_SKIP, v.skip);
    check($sformatf("v%0d moving", n), MOVING, v.mov);
    check($sformatf("v%0d period_valid", n), PERIOD_VALID, v.perv);
    if (v.chk_per) check($sformatf("v%0d step_period", n), STEP_PERIOD, v.per);
  endtask

  initial begin
    int f0, r0, lat, mk_cnt;
    logic seen;

    //             pat      hold  cp ce pos       f  r  dir idx pv il sk mv perv chk per
    vecs.push_back(mk(4'b1000, 1000, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1100, 1000, 0, 0, 16'h0001, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(4'b0100, 1000, 0, 0, 16'h0002, 1, 0, 1, 2, 1, 0, 0, 1, 1, 1, 1000));
    vecs.push_back(mk(4'b0110, 1000, 0, 0, 16'h0003, 1, 0, 1, 3, 1, 0, 0, 1, 1, 1, 1000));
    vecs.push_back(mk(4'b0010, 1000, 0, 0, 16'h0004, 1, 0, 1, 4, 1, 0, 0, 1, 1, 1, 1000));
    vecs.push_back(mk(4'b0011, 1000, 0, 0, 16'h0005, 1, 0, 1, 5, 1, 0, 0, 1, 1, 1, 1000));
    vecs.push_back(mk(4'b0001, 1000, 0, 0, 16'h0006, 1, 0, 1, 6, 1, 0, 0, 1, 1, 1, 1000));
    vecs.push_back(mk(4'b1001, 1000, 0, 0, 16'h0007, 1, 0, 1, 7, 1, 0, 0, 1, 1, 1, 1000));
    vecs.push_back(mk(4'b1000, 1000, 0, 0, 16'h0008, 1, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1000));
    vecs.push_back(mk(4'b1000,   40, 1, 0, 16'h0000, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1000));
    vecs.push_back(mk(4'b1001,   40, 0, 0, 16'hFFFF, 0, 1, 0, 7, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0001,   40, 0, 0, 16'hFFFE, 0, 1, 0, 6, 1, 0, 0, 1, 1, 1, 40));
    vecs.push_back(mk(4'b0011,   40, 0, 0, 16'hFFFD, 0, 1, 0, 5, 1, 0, 0, 1, 1, 1, 40));
    vecs.push_back(mk(4'b1000,   40, 0, 0, 16'hFFFD, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(4'b1000,   40, 0, 1, 16'hFFFD, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0100,   40, 0, 0, 16'hFFFD, 0, 0, 0, 2, 1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0110,   40, 0, 0, 16'hFFFE, 1, 0, 1, 3, 1, 0, 1, 1, 1, 1, 160));
    vecs.push_back(mk(4'b0110,   40, 0, 1, 16'hFFFE, 0, 0, 1, 3, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(4'b1010,   40, 0, 0, 16'hFFFE, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1000,   40, 0, 0, 16'hFFFE, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b0000,   40, 0, 0, 16'hFFFE, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'b1000,   40, 0, 0, 16'hFFFE, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));

    pins = 4'b0000; CLR_POS = 1'b0; CLR_ERR = 1'b0; RST_N = 1'b0;
    repeat (3) @(negedge CLK_50M);
    #1;
    check("reset position", POSITION, 16'h0000);
    check("reset flags", {STEP_FWD, STEP_REV, DIR, MOVING, PHASE_VALID, PERIOD_VALID, ERR_ILLEGAL, ERR_SKIP}, 8'h00);
    check("reset phase_idx", PHASE_IDX, 3'd0);
    check("reset step_period", STEP_PERIOD, 24'd0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK_50M);
    #1;

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Glitch one clock shorter than the filter window: no effect.
    f0 = fwd_total; r0 = rev_total;
    pins = 4'b1100;
    repeat (STABLE - 1) @(negedge CLK_50M);
    pins = 4'b1000;
    repeat (40) @(negedge CLK_50M);
    #1;
    check("short glitch fwd", fwd_total - f0, 0);
    check("short glitch rev", rev_total - r0, 0);
    check("short glitch position", POSITION, 16'hFFFE);

    // Pulse one clock longer than the window: accepted, with fixed pin-to-pulse latency.
    f0 = fwd_total; r0 = rev_total; lat = 0;
    pins = 4'b1100;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK_50M);
      if (k == STABLE + 1) pins = 4'b1000;
      if (STEP_FWD && lat == 0) lat = k;
    end
    #1;
    check("long pulse fwd", fwd_total - f0, 1);
    check("long pulse rev", rev_total - r0, 1);
    check("step latency", lat, LAT);
    check("long pulse position", POSITION, 16'hFFFE);

    // MOVING times out IDLE_T clocks after the last accepted step.
    pins = 4'b1100;
    seen = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK_50M);
      if (STEP_FWD) begin
        seen = 1'b1;
        break;
      end
    end
    check("idle test step seen", seen, 1'b1);
    check("moving at step", MOVING, 1'b1);
    mk_cnt = 0;
    for (int k = 1; k <= IDLE_T + 20; k++) begin
      @(negedge CLK_50M);
      if (!MOVING) begin
        mk_cnt = k;
        break;
      end
    end
    check("moving drop time", mk_cnt, IDLE_T);
    check("idle position", POSITION, 16'hFFFF);
    #1;

    // Asynchronous reset mid-filter, then the first legal pattern becomes the new reference.
    pins = 4'b0110;
    repeat (10) @(negedge CLK_50M);
    RST_N = 1'b0;
    #1;
    check("mid reset position", POSITION, 16'h0000);
    check("mid reset flags", {STEP_FWD, STEP_REV, DIR, MOVING, PHASE_VALID, PERIOD_VALID, ERR_ILLEGAL, ERR_SKIP}, 8'h00);
    check("mid reset period", STEP_PERIOD, 24'd0);
    @(negedge CLK_50M);
    RST_N = 1'b1;
    f0 = fwd_total; r0 = rev_total;
    repeat (40) @(negedge CLK_50M);
    #1;
    check("post reset steps", (fwd_total - f0) + (rev_total - r0), 0);
    check("post reset phase_idx", PHASE_IDX, 3'd3);
    check("post reset phase_valid", PHASE_VALID, 1'b1);

    // CLR_POS on the step cycle wins over the count; the pulse still appears.
    pins = 4'b0010;
    repeat (40) @(negedge CLK_50M);
    #1;
    check("pre clear position", POSITION, 16'h0001);
    pins = 4'b0011;
    repeat (LAT - 1) @(negedge CLK_50M);
    CLR_POS = 1'b1;
    @(negedge CLK_50M);
    check("clr_pos step pulse", STEP_FWD, 1'b1);
    check("clr_pos wins", POSITION, 16'h0000);
    CLR_POS = 1'b0;
    repeat (5) @(negedge CLK_50M);

    // CLR_ERR coincident with a new illegal pattern leaves the flag set.
    pins = 4'b1010;
    repeat (LAT - 1) @(negedge CLK_50M);
    CLR_ERR = 1'b1;
    @(negedge CLK_50M);
    check("clr_err vs new error", ERR_ILLEGAL, 1'b1);
    CLR_ERR = 1'b0;
    @(negedge CLK_50M);
    check("illegal drops phase_valid", PHASE_VALID, 1'b0);
    CLR_ERR = 1'b1;
    @(negedge CLK_50M);
    CLR_ERR = 1'b0;
    check("clr_err clears", ERR_ILLEGAL, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
